// File: rtl/expipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : expipe_pkg
// Description : Execution-pipeline types and helpers for the divider unit.
// Revision    : 1.0 - initial release
// ============================================================================
package expipe_pkg;
   import len5_pkg::*;

   typedef enum logic [3:0] {
      DIV   = 4'd0,
      DIVU  = 4'd1,
      REM   = 4'd2,
      REMU  = 4'd3,
      DIVW  = 4'd4,
      DIVUW = 4'd5,
      REMW  = 4'd6,
      REMUW = 4'd7
   } div_ctl_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_t;

   localparam int DIV_CNT_LEN = $clog2(XLEN) + 1;

   // Unassigned codes fall back to DIVU.
   function automatic div_ctl_t div_decode(input logic [3:0] code);
      return code[3] ? DIVU : div_ctl_t'(code);
   endfunction

   function automatic logic div_is_word(input div_ctl_t op);
      return op[2];
   endfunction

   function automatic logic div_is_signed(input div_ctl_t op);
      return ~op[0];
   endfunction

   function automatic logic div_is_rem(input div_ctl_t op);
      return op[1];
   endfunction
endpackage
`default_nettype wire

// File: rtl/len5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : len5_pkg
// Description : Core-wide datapath constants.
// Revision    : 1.0 - initial release
// ============================================================================
package len5_pkg;
   localparam int XLEN = 64;
endpackage
`default_nettype wire

// File: rtl/div_lzc.sv
`default_nettype none
// ============================================================================
// Module      : div_lzc
// Description : Combinational leading-zero counter; all-zero input gives W.
// Revision    : 1.0 - initial release
// ============================================================================
module div_lzc #(
   parameter int W  = 64,
   parameter int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  i_data,
   output logic [CW-1:0] o_cnt
);
   always_comb begin
      o_cnt = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (i_data[i]) o_cnt = CW'(W - 1 - i);
      end
   end
endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for RV64M DIV/REM ops.
//               Optional macro DIV_EARLY_OUT_EN skips dividend leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
   import len5_pkg::*;
   import expipe_pkg::*;
#(
   parameter int EU_CTL_LEN = 4,
   parameter int RS_DEPTH   = 16,
   parameter int EXCEPT_LEN = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [EU_CTL_LEN-1:0]       ctl_i,
   input  logic [XLEN-1:0]             rs1_i,
   input  logic [XLEN-1:0]             rs2_i,
   input  logic [$clog2(RS_DEPTH)-1:0] entry_idx_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [$clog2(RS_DEPTH)-1:0] entry_idx_o,
   output logic [XLEN-1:0]             result_o,
   output logic                        except_raised_o,
   output logic [EXCEPT_LEN-1:0]       except_code_o
);
   localparam int IDX_W  = $clog2(RS_DEPTH);
   localparam int c_WLEN = 32;

   div_state_t             r_state, w_next;
   logic [EU_CTL_LEN-1:0]  r_ctl;
   logic [XLEN-1:0]        r_a, r_b, r_q, r_r, r_result;
   logic [IDX_W-1:0]       r_idx;
   logic [DIV_CNT_LEN-1:0] r_cnt;
   logic                   r_qneg, r_rneg, r_special;

   div_ctl_t               w_op;
   logic                   w_word, w_sgn, w_rem, w_accept;
   logic                   w_sign_a, w_sign_b, w_b_zero, w_ovf, w_special;
   logic [XLEN-1:0]        w_an, w_bn, w_mag_a, w_mag_b, w_min;
   logic [XLEN-1:0]        w_qf, w_rf, w_sel, w_res;
   logic [XLEN:0]          w_sh, w_diff;
   logic [DIV_CNT_LEN-1:0] w_shamt, w_iters;

   assign w_op     = div_decode(r_ctl[3:0]);
   assign w_word   = div_is_word(w_op);
   assign w_sgn    = div_is_signed(w_op);
   assign w_rem    = div_is_rem(w_op);
   assign w_accept = (r_state == IDLE) && valid_i && !flush_i;

   // Word operands live zero-extended in the low half; signs come from bit 31.
   assign w_sign_a = w_word ? r_a[c_WLEN-1] : r_a[XLEN-1];
   assign w_sign_b = w_word ? r_b[c_WLEN-1] : r_b[XLEN-1];
   assign w_an     = w_word ? {{(XLEN-c_WLEN){1'b0}}, r_a[c_WLEN-1:0]} : r_a;
   assign w_bn     = w_word ? {{(XLEN-c_WLEN){1'b0}}, r_b[c_WLEN-1:0]} : r_b;
   assign w_mag_a  = (w_sgn && w_sign_a)
                   ? (w_word ? {{(XLEN-c_WLEN){1'b0}}, -r_a[c_WLEN-1:0]} : -r_a) : w_an;
   assign w_mag_b  = (w_sgn && w_sign_b)
                   ? (w_word ? {{(XLEN-c_WLEN){1'b0}}, -r_b[c_WLEN-1:0]} : -r_b) : w_bn;
   assign w_min    = w_word ? {{(XLEN-c_WLEN){1'b0}}, 1'b1, {(c_WLEN-1){1'b0}}}
                            : {1'b1, {(XLEN-1){1'b0}}};
   assign w_b_zero = (w_bn == '0);
   assign w_ovf    = w_sgn && (w_an == w_min) &&
                     (w_word ? (r_b[c_WLEN-1:0] == '1) : (r_b == '1));
   assign w_special = w_b_zero || w_ovf;

   // The dividend is left-aligned so the next quotient bit is always bit XLEN-1.
`ifdef DIV_EARLY_OUT_EN
   logic [DIV_CNT_LEN-1:0] w_lz;

   div_lzc #(.W(XLEN), .CW(DIV_CNT_LEN)) u_lzc (
      .i_data (w_mag_a),
      .o_cnt  (w_lz)
   );

   assign w_shamt = w_lz;
   assign w_iters = DIV_CNT_LEN'(XLEN) - w_lz;
`else
   assign w_shamt = w_word ? DIV_CNT_LEN'(XLEN - c_WLEN) : '0;
   assign w_iters = w_word ? DIV_CNT_LEN'(c_WLEN) : DIV_CNT_LEN'(XLEN);
`endif

   assign w_sh   = {r_r, r_q[XLEN-1]};
   assign w_diff = w_sh - {1'b0, r_b};

   assign w_qf  = r_qneg ? -r_q : r_q;
   assign w_rf  = r_rneg ? -r_r : r_r;
   assign w_sel = w_rem ? w_rf : w_qf;
   assign w_res = w_word ? {{(XLEN-c_WLEN){w_sel[c_WLEN-1]}}, w_sel[c_WLEN-1:0]} : w_sel;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (valid_i) w_next = INIT;
         INIT: w_next = (w_special || (w_iters == '0)) ? FIX : ITER;
         ITER: if (r_cnt == DIV_CNT_LEN'(1)) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: if (ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (flush_i) w_next = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ctl     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_q       <= '0;
         r_r       <= '0;
         r_cnt     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_special <= 1'b0;
         r_idx     <= '0;
         r_result  <= '0;
      end else if (!flush_i) begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_ctl <= ctl_i;
               r_a   <= rs1_i;
               r_b   <= rs2_i;
               r_idx <= entry_idx_i;
            end
            INIT: begin
               r_special <= w_special;
               r_qneg    <= w_sgn && !w_special && (w_sign_a ^ w_sign_b);
               r_rneg    <= w_sgn && !w_special && w_sign_a;
               r_cnt     <= w_iters;
               r_b       <= w_mag_b;
               if (w_b_zero) begin
                  r_q <= '1;
                  r_r <= w_an;
               end else if (w_ovf) begin
                  r_q <= w_min;
                  r_r <= '0;
               end else begin
                  r_q <= w_mag_a << w_shamt;
                  r_r <= '0;
               end
            end
            ITER: begin
               if (!w_diff[XLEN]) begin
                  r_r <= w_diff[XLEN-1:0];
                  r_q <= {r_q[XLEN-2:0], 1'b1};
               end else begin
                  r_r <= w_sh[XLEN-1:0];
                  r_q <= {r_q[XLEN-2:0], 1'b0};
               end
               r_cnt <= r_cnt - DIV_CNT_LEN'(1);
            end
            FIX:     r_result <= w_res;
            default: ;
         endcase
      end
   end

   assign ready_o         = (r_state == IDLE);
   assign valid_o         = (r_state == DONE);
   assign entry_idx_o     = r_idx;
   assign result_o        = r_result;
   assign except_raised_o = 1'b0;
   assign except_code_o   = '0;
endmodule
`default_nettype wire
